// File: rtl/mult_div_seq_pkg.sv
// ============================================================================
// Module      : mult_div_pkg
// Description : Shared types, opcode constants and helpers for mult_div_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_div_pkg;

  // Sequencer states of the multiply/divide unit
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // op_div encoding
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Widest operand abs_val can handle; callers sign-extend into this width
  localparam int ABS_MAX_W = 128;
  typedef logic [ABS_MAX_W-1:0] absw_t;

  // Magnitude of a sign-extended value. The most-negative WIDTH-bit value
  // comes out as 1 followed by zeros, which is its correct unsigned magnitude
  // once the caller truncates back to WIDTH bits.
  function automatic absw_t abs_val(input absw_t value, input logic is_signed);
    absw_t r;
    if (is_signed && value[ABS_MAX_W-1]) begin
      r = ~value + absw_t'(1);
    end else begin
      r = value;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_div_seq_if.sv
// ============================================================================
// Module      : mult_div_seq_if
// Description : Request/result bundle between the core control FSM (master)
//               and the sequential multiply/divide unit (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_div;
  logic             op_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op_div, op_signed, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op_div, op_signed, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/mult_div_seq.sv
// ============================================================================
// Module      : mult_div_seq
// Description : Sequential radix-2 multiply / restoring divide unit with HI/LO
//               result registers and a start/busy/done handshake. Multiply and
//               divide share one accumulator, shifter and adder.
//               Optional macro MULT_DIV_DIVZERO_EXC_EN: divide-by-zero is
//               flagged on div_zero and finishes early without touching hi/lo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic    clk,
  input  wire logic    reset,   // asynchronous, active-low
  mult_div_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q;    // mult: upper accumulator, div: partial remainder
  logic [WIDTH-1:0] lq_q;     // mult: multiplier/low product, div: dividend/quotient
  logic [WIDTH-1:0] opnd_q;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             op_div_q, sa_q, sb_q, dz_q;
`ifndef MULT_DIV_DIVZERO_EXC_EN
  logic [WIDTH-1:0] araw_q;   // raw dividend pattern for the forced /0 result
`endif

  logic             w_b_zero;
  absw_t            w_a_ext, w_b_ext;
  logic [WIDTH-1:0] w_a_abs, w_b_abs;
  logic             w_last;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_opa, w_opb, w_sum;
  logic             w_div_neg;
  logic [WIDTH:0]   w_mstep;
  logic [WIDTH-1:0] w_fix_hi, w_fix_lo;

  // Operand magnitudes at acceptance; sign extension feeds the shared helper
  assign w_b_zero = (bus.b == '0);
  assign w_a_ext  = {{(ABS_MAX_W-WIDTH){bus.a[WIDTH-1]}}, bus.a};
  assign w_b_ext  = {{(ABS_MAX_W-WIDTH){bus.b[WIDTH-1]}}, bus.b};
  assign w_a_abs  = WIDTH'(abs_val(w_a_ext, bus.op_signed));
  assign w_b_abs  = WIDTH'(abs_val(w_b_ext, bus.op_signed));
  assign w_last   = (cnt_q == CNT_W'(1));

  // Shared adder: add multiplicand (mult) or trial-subtract divisor (div).
  // Two guard bits keep the carry of the add and the borrow of the subtract.
  assign w_rem_sh = {acc_q, lq_q[WIDTH-1]};
  always_comb begin
    if (op_div_q == OP_DIV) begin
      w_opa = {1'b0, w_rem_sh};
      w_opb = ~{2'b00, opnd_q};
    end else begin
      w_opa = {2'b00, acc_q};
      w_opb = {2'b00, opnd_q};
    end
  end
  assign w_sum     = w_opa + w_opb + {{(WIDTH+1){1'b0}}, op_div_q};
  assign w_div_neg = w_sum[WIDTH+1];
  assign w_mstep   = lq_q[0] ? w_sum[WIDTH:0] : {1'b0, acc_q};

  // Sign correction applied in FIX (truncating division semantics)
  always_comb begin
    w_fix_hi = acc_q;
    w_fix_lo = lq_q;
    if (op_div_q == OP_MUL) begin
      if (sa_q ^ sb_q) begin
        {w_fix_hi, w_fix_lo} = -{acc_q, lq_q};
      end
    end else begin
      if (sa_q ^ sb_q) begin
        w_fix_lo = -lq_q;
      end
      if (sa_q) begin
        w_fix_hi = -acc_q;
      end
`ifndef MULT_DIV_DIVZERO_EXC_EN
      if (dz_q) begin
        w_fix_hi = araw_q;
        w_fix_lo = '1;
      end
`endif
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
`ifdef MULT_DIV_DIVZERO_EXC_EN
          state_d = (bus.op_div == OP_DIV && w_b_zero) ? DONE : RUN;
`else
          state_d = RUN;
`endif
        end
      end
      RUN:     if (w_last) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    bus.busy     = (state_q == RUN) || (state_q == FIX);
    bus.done     = (state_q == DONE);
`ifdef MULT_DIV_DIVZERO_EXC_EN
    bus.div_zero = (state_q == DONE) && dz_q;
`else
    bus.div_zero = 1'b0;
`endif
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

  // Datapath: capture in IDLE, iterate in RUN, load results in FIX
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      lq_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      op_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
`ifndef MULT_DIV_DIVZERO_EXC_EN
      araw_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_div_q <= bus.op_div;
            sa_q     <= bus.op_signed & bus.a[WIDTH-1];
            sb_q     <= bus.op_signed & bus.b[WIDTH-1];
            dz_q     <= (bus.op_div == OP_DIV) && w_b_zero;
            acc_q    <= '0;
            cnt_q    <= CNT_W'(WIDTH);
            if (bus.op_div == OP_DIV) begin
              lq_q   <= w_a_abs;
              opnd_q <= w_b_abs;
            end else begin
              lq_q   <= w_b_abs;
              opnd_q <= w_a_abs;
            end
`ifndef MULT_DIV_DIVZERO_EXC_EN
            araw_q   <= bus.a;
`endif
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (op_div_q == OP_DIV) begin
            acc_q <= w_div_neg ? w_rem_sh[WIDTH-1:0] : w_sum[WIDTH-1:0];
            lq_q  <= {lq_q[WIDTH-2:0], ~w_div_neg};
          end else begin
            acc_q <= w_mstep[WIDTH:1];
            lq_q  <= {w_mstep[0], lq_q[WIDTH-1:1]};
          end
        end
        FIX: begin
          hi_q <= w_fix_hi;
          lo_q <= w_fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
